// File: rtl/ray_sweep_ctrl_pkg.sv
// Shared definitions for the ray sweep controller: FSM encodings, angle
// format constants, the "no hit" distance and the squared-distance helper.
package ray_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SELECT = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  localparam int          ANGLE_FRAC_BITS = 9;
  localparam int          DEG_360         = 360;
  localparam logic [26:0] DIST_MAX        = '1;
  localparam int          TIMEOUT_BITS    = 12;

  // Squared euclidean distance between two 13-bit signed points. The worst
  // case (2 * 8191^2) still fits in 27 bits, so the result is exact.
  function automatic logic [26:0] dist_sq(input logic signed [12:0] ax,
                                          input logic signed [12:0] ay,
                                          input logic signed [12:0] bx,
                                          input logic signed [12:0] by);
    logic signed [13:0] dx, dy;
    logic signed [27:0] dxe, dye, dx2, dy2;
    logic [27:0]        sum;
    dx  = $signed({ax[12], ax}) - $signed({bx[12], bx});
    dy  = $signed({ay[12], ay}) - $signed({by[12], by});
    dxe = 28'(dx);
    dye = 28'(dy);
    dx2 = dxe * dxe;
    dy2 = dye * dye;
    sum = dx2 + dy2;
    return sum[26:0];
  endfunction

endpackage

// File: rtl/ray_sweep_ctrl_dist_select.sv
// Combinational hit selector: picks the nearer of the horizontal and
// vertical finder hits relative to the player. Ties go to horizontal.
module ray_dist_select
  import ray_sweep_ctrl_pkg::*;
(
  input  logic signed [12:0] px,
  input  logic signed [12:0] py,
  input  logic signed [12:0] h_x,
  input  logic signed [12:0] h_y,
  input  logic               h_found,
  input  logic signed [12:0] v_x,
  input  logic signed [12:0] v_y,
  input  logic               v_found,
  output logic signed [12:0] sel_x,
  output logic signed [12:0] sel_y,
  output logic [26:0]        sel_dist,
  output logic               sel_hit,
  output logic               sel_vert
);

  logic [26:0] h_dist, v_dist;
  logic        take_v;

  assign h_dist = dist_sq(h_x, h_y, px, py);
  assign v_dist = dist_sq(v_x, v_y, px, py);

  // Choose the source, then drive the selected hit (or the no-hit values).
  always_comb begin
    take_v   = 1'b0;
    sel_x    = '0;
    sel_y    = '0;
    sel_dist = DIST_MAX;
    sel_hit  = 1'b0;
    sel_vert = 1'b0;
    if (h_found && v_found) take_v = (v_dist < h_dist);
    else                    take_v = v_found;
    if (h_found || v_found) begin
      sel_hit  = 1'b1;
      sel_vert = take_v;
      sel_x    = take_v ? v_x    : h_x;
      sel_y    = take_v ? v_y    : h_y;
      sel_dist = take_v ? v_dist : h_dist;
    end
  end

endmodule

// File: rtl/ray_sweep_ctrl.sv
// Ray sweep controller: walks the ray angle across NUM_COLS columns, fires
// both intersection finders per column, keeps the nearer hit and hands it to
// the renderer. Optional macro RAY_TIMEOUT_EN adds a 4096-cycle finder
// timeout in S_WAIT.
// Renderer handshake: col_valid rises in S_OUTPUT and holds with stable data
// until a rising clock edge sees col_valid && col_ready; that edge accepts.
module ray_sweep_ctrl
  import ray_sweep_ctrl_pkg::*;
#(
  parameter int NUM_COLS        = 320,
  parameter int ANGLE_STEP_FRAC = 96,
  parameter int HALF_FOV        = 30
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               frame_start,
  input  logic signed [12:0] playerX,
  input  logic signed [12:0] playerY,
  input  logic [8:0]         player_angle,
  output logic signed [9:0]  alpha_X,
  output logic signed [9:0]  alpha_Y,
  output logic               begin_calc,
  input  logic signed [12:0] h_wallX,
  input  logic signed [12:0] h_wallY,
  input  logic signed [12:0] v_wallX,
  input  logic signed [12:0] v_wallY,
  input  logic               h_wall_found,
  input  logic               h_end_calc,
  input  logic               v_wall_found,
  input  logic               v_end_calc,
  output logic               col_valid,
  input  logic               col_ready,
  output logic [8:0]         col_index,
  output logic signed [12:0] col_wallX,
  output logic signed [12:0] col_wallY,
  output logic [26:0]        col_dist_sq,
  output logic               col_hit,
  output logic               col_is_vert,
  output logic               busy,
  output logic               frame_done,
  output logic [2:0]         dbg_state
);

  state_t             state_q, state_d;
  logic [9:0]         alpha_x_q, alpha_x_d, alpha_y_q, alpha_y_d;
  logic [8:0]         col_index_q, col_index_d;
  logic signed [12:0] px_q, px_d, py_q, py_d;
  logic               h_done_q, h_done_d, v_done_q, v_done_d;
  logic signed [12:0] h_x_q, h_x_d, h_y_q, h_y_d, v_x_q, v_x_d, v_y_q, v_y_d;
  logic               h_found_q, h_found_d, v_found_q, v_found_d;
  logic signed [12:0] cx_q, cx_d, cy_q, cy_d;
  logic [26:0]        cdist_q, cdist_d;
  logic               chit_q, chit_d, cvert_q, cvert_d;
  logic               frame_done_q, frame_done_d;

  logic signed [12:0] sel_x, sel_y;
  logic [26:0]        sel_dist;
  logic               sel_hit, sel_vert;
  logic [9:0]         start_deg;
  logic [9:0]         step;

`ifdef RAY_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] timer_q, timer_d;
`endif

  ray_dist_select u_sel (
    .px(px_q), .py(py_q),
    .h_x(h_x_q), .h_y(h_y_q), .h_found(h_found_q),
    .v_x(v_x_q), .v_y(v_y_q), .v_found(v_found_q),
    .sel_x(sel_x), .sel_y(sel_y), .sel_dist(sel_dist),
    .sel_hit(sel_hit), .sel_vert(sel_vert)
  );

  assign step = 10'(ANGLE_STEP_FRAC);

  // First ray angle: player angle plus half the FOV, wrapped into 0..359.
  always_comb begin
    start_deg = {1'b0, player_angle} + 10'(HALF_FOV);
    if (start_deg >= 10'(DEG_360)) start_deg = start_deg - 10'(DEG_360);
  end

  // Next-state and datapath updates for the sweep FSM.
  always_comb begin
    state_d      = state_q;
    alpha_x_d    = alpha_x_q;
    alpha_y_d    = alpha_y_q;
    col_index_d  = col_index_q;
    px_d         = px_q;
    py_d         = py_q;
    h_done_d     = h_done_q;
    v_done_d     = v_done_q;
    h_x_d        = h_x_q;
    h_y_d        = h_y_q;
    h_found_d    = h_found_q;
    v_x_d        = v_x_q;
    v_y_d        = v_y_q;
    v_found_d    = v_found_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    cdist_d      = cdist_q;
    chit_d       = chit_q;
    cvert_d      = cvert_q;
    frame_done_d = 1'b0;
`ifdef RAY_TIMEOUT_EN
    timer_d      = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          px_d        = playerX;
          py_d        = playerY;
          col_index_d = '0;
          alpha_x_d   = start_deg;
          alpha_y_d   = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        h_done_d = 1'b0;
        v_done_d = 1'b0;
`ifdef RAY_TIMEOUT_EN
        timer_d  = '0;
`endif
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (h_end_calc) begin
          h_done_d  = 1'b1;
          h_x_d     = h_wallX;
          h_y_d     = h_wallY;
          h_found_d = h_wall_found;
        end
        if (v_end_calc) begin
          v_done_d  = 1'b1;
          v_x_d     = v_wallX;
          v_y_d     = v_wallY;
          v_found_d = v_wall_found;
        end
`ifdef RAY_TIMEOUT_EN
        timer_d = timer_q + 1'b1;
        if (&timer_q) begin
          if (!h_done_d) begin
            h_done_d  = 1'b1;
            h_found_d = 1'b0;
          end
          if (!v_done_d) begin
            v_done_d  = 1'b1;
            v_found_d = 1'b0;
          end
        end
`endif
        if (h_done_d && v_done_d) state_d = S_SELECT;
      end
      S_SELECT: begin
        cx_d    = sel_x;
        cy_d    = sel_y;
        cdist_d = sel_dist;
        chit_d  = sel_hit;
        cvert_d = sel_vert;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (col_ready) begin
          // Step the ray clockwise, borrowing a degree when the fraction underflows.
          if (alpha_y_q >= step) begin
            alpha_y_d = alpha_y_q - step;
          end else begin
            alpha_y_d = alpha_y_q + 10'(1 << ANGLE_FRAC_BITS) - step;
            alpha_x_d = (alpha_x_q == '0) ? 10'(DEG_360 - 1) : alpha_x_q - 10'd1;
          end
          col_index_d = col_index_q + 9'd1;
          if (col_index_q == 9'(NUM_COLS - 1)) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      alpha_x_q    <= '0;
      alpha_y_q    <= '0;
      col_index_q  <= '0;
      px_q         <= '0;
      py_q         <= '0;
      h_done_q     <= 1'b0;
      v_done_q     <= 1'b0;
      h_x_q        <= '0;
      h_y_q        <= '0;
      h_found_q    <= 1'b0;
      v_x_q        <= '0;
      v_y_q        <= '0;
      v_found_q    <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      cdist_q      <= '0;
      chit_q       <= 1'b0;
      cvert_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      alpha_x_q    <= alpha_x_d;
      alpha_y_q    <= alpha_y_d;
      col_index_q  <= col_index_d;
      px_q         <= px_d;
      py_q         <= py_d;
      h_done_q     <= h_done_d;
      v_done_q     <= v_done_d;
      h_x_q        <= h_x_d;
      h_y_q        <= h_y_d;
      h_found_q    <= h_found_d;
      v_x_q        <= v_x_d;
      v_y_q        <= v_y_d;
      v_found_q    <= v_found_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      cdist_q      <= cdist_d;
      chit_q       <= chit_d;
      cvert_q      <= cvert_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef RAY_TIMEOUT_EN
  // Finder timeout counter, only present when the timeout is enabled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`endif

  assign alpha_X     = $signed(alpha_x_q);
  assign alpha_Y     = $signed(alpha_y_q);
  assign begin_calc  = (state_q == S_ISSUE);
  assign col_valid   = (state_q == S_OUTPUT);
  assign col_index   = col_index_q;
  assign col_wallX   = cx_q;
  assign col_wallY   = cy_q;
  assign col_dist_sq = cdist_q;
  assign col_hit     = chit_q;
  assign col_is_vert = cvert_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = frame_done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ray_sweep_ctrl.sv
// Directed testbench for ray_sweep_ctrl: angle stepping, hit selection,
// finder timing, renderer backpressure, frame completion and reset.
module tb_ray_sweep_ctrl;

  logic               clock, resetn, frame_start;
  logic signed [12:0] playerX, playerY;
  logic [8:0]         player_angle;
  logic signed [9:0]  alpha_X, alpha_Y;
  logic               begin_calc;
  logic signed [12:0] h_wallX, h_wallY, v_wallX, v_wallY;
  logic               h_wall_found, h_end_calc, v_wall_found, v_end_calc;
  logic               col_valid, col_ready;
  logic [8:0]         col_index;
  logic signed [12:0] col_wallX, col_wallY;
  logic [26:0]        col_dist_sq;
  logic               col_hit, col_is_vert, busy, frame_done;
  logic [2:0]         dbg_state;

  int checks = 0;
  int passed = 0;
  int fd_count = 0;
  int exp_total;
  int exp_idx;

  ray_sweep_ctrl dut (
    .clock(clock), .resetn(resetn), .frame_start(frame_start),
    .playerX(playerX), .playerY(playerY), .player_angle(player_angle),
    .alpha_X(alpha_X), .alpha_Y(alpha_Y), .begin_calc(begin_calc),
    .h_wallX(h_wallX), .h_wallY(h_wallY), .v_wallX(v_wallX), .v_wallY(v_wallY),
    .h_wall_found(h_wall_found), .h_end_calc(h_end_calc),
    .v_wall_found(v_wall_found), .v_end_calc(v_end_calc),
    .col_valid(col_valid), .col_ready(col_ready), .col_index(col_index),
    .col_wallX(col_wallX), .col_wallY(col_wallY), .col_dist_sq(col_dist_sq),
    .col_hit(col_hit), .col_is_vert(col_is_vert), .busy(busy),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // Clock and frame_done pulse counter.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(negedge clock) if (frame_done === 1'b1) fd_count++;

  task automatic apply_reset();
    resetn = 1'b0; frame_start = 1'b0; col_ready = 1'b0;
    h_end_calc = 1'b0; v_end_calc = 1'b0; h_wall_found = 1'b0; v_wall_found = 1'b0;
    h_wallX = '0; h_wallY = '0; v_wallX = '0; v_wallY = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic start_frame(input logic [8:0] ang);
    playerX = 13'sd100; playerY = 13'sd100; player_angle = ang;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    exp_total = ((int'(ang) + 30) % 360) * 512;
    exp_idx = 0;
  endtask

  // One column: check the issued ray, play the finders, check the selected
  // hit, optionally stall the renderer, then accept and advance the model.
  task automatic run_column(input int hd, input int vd,
                            input logic signed [12:0] hx, input logic signed [12:0] hy,
                            input logic hf,
                            input logic signed [12:0] vx, input logic signed [12:0] vy,
                            input logic vf, input int hold,
                            input logic signed [12:0] ex, input logic signed [12:0] ey,
                            input logic [26:0] ed, input logic eh, input logic ev);
    int n;
    int maxd;
    logic stable;
    n = 0;
    col_ready = 1'b0;
    while (begin_calc !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (begin_calc !== 1'b1) $display("FAIL begin_calc_timeout col %0d: got %b expected 1", exp_idx, begin_calc);
    else passed++;
    checks++;
    if ($signed(alpha_X) !== exp_total / 512) $display("FAIL alpha_X col %0d: got %0d expected %0d", exp_idx, alpha_X, exp_total / 512);
    else passed++;
    checks++;
    if ($signed(alpha_Y) !== exp_total % 512) $display("FAIL alpha_Y col %0d: got %0d expected %0d", exp_idx, alpha_Y, exp_total % 512);
    else passed++;
    checks++;
    if (int'(col_index) !== exp_idx) $display("FAIL col_index col %0d: got %0d expected %0d", exp_idx, col_index, exp_idx);
    else passed++;
    @(negedge clock);
    checks++;
    if (begin_calc !== 1'b0 || busy !== 1'b1) $display("FAIL begin_calc_pulse col %0d: got %b/%b expected 0/1", exp_idx, begin_calc, busy);
    else passed++;
    maxd = (hd > vd) ? hd : vd;
    for (int c = 0; c <= maxd; c++) begin
      h_end_calc   = (c == hd);
      h_wallX      = (c == hd) ? hx : 13'sd170;
      h_wallY      = (c == hd) ? hy : -13'sd170;
      h_wall_found = (c == hd) ? hf : !hf;
      v_end_calc   = (c == vd);
      v_wallX      = (c == vd) ? vx : -13'sd333;
      v_wallY      = (c == vd) ? vy : 13'sd333;
      v_wall_found = (c == vd) ? vf : !vf;
      @(negedge clock);
    end
    h_end_calc = 1'b0; v_end_calc = 1'b0;
    n = 0;
    while (col_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (col_valid !== 1'b1) $display("FAIL col_valid_timeout col %0d: got %b expected 1", exp_idx, col_valid);
    else passed++;
    checks++;
    if (col_wallX !== ex || col_wallY !== ey) $display("FAIL col_wall col %0d: got (%0d,%0d) expected (%0d,%0d)", exp_idx, col_wallX, col_wallY, ex, ey);
    else passed++;
    checks++;
    if (col_dist_sq !== ed) $display("FAIL col_dist_sq col %0d: got %0d expected %0d", exp_idx, col_dist_sq, ed);
    else passed++;
    checks++;
    if (col_hit !== eh || col_is_vert !== ev) $display("FAIL col_flags col %0d: got hit=%b vert=%b expected hit=%b vert=%b", exp_idx, col_hit, col_is_vert, eh, ev);
    else passed++;
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      stable = (col_valid === 1'b1) && (col_wallX === ex) && (col_wallY === ey) &&
               (col_dist_sq === ed) && (int'(col_index) === exp_idx);
      checks++;
      if (!stable) $display("FAIL hold_stable col %0d cycle %0d: got valid=%b idx=%0d dist=%0d expected 1/%0d/%0d", exp_idx, k, col_valid, col_index, col_dist_sq, exp_idx, ed);
      else passed++;
    end
    col_ready = 1'b1;
    @(negedge clock);
    col_ready = 1'b0;
    exp_total = exp_total - 96;
    if (exp_total < 0) exp_total = exp_total + 360 * 512;
    exp_idx++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; frame_start = 1'b0; col_ready = 1'b0;
    h_end_calc = 1'b0; v_end_calc = 1'b0; h_wall_found = 1'b0; v_wall_found = 1'b0;
    h_wallX = '0; h_wallY = '0; v_wallX = '0; v_wallY = '0;
    playerX = '0; playerY = '0; player_angle = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || col_valid !== 1'b0 || begin_calc !== 1'b0 || frame_done !== 1'b0 || dbg_state !== 3'd0)
      $display("FAIL reset_ctrl: got busy=%b valid=%b begin=%b done=%b state=%0d expected all 0", busy, col_valid, begin_calc, frame_done, dbg_state);
    else passed++;
    checks++;
    if (alpha_X !== 10'sd0 || alpha_Y !== 10'sd0 || col_index !== 9'd0 || col_hit !== 1'b0 || col_dist_sq !== 27'd0)
      $display("FAIL reset_data: got ax=%0d ay=%0d idx=%0d hit=%b dist=%0d expected 0", alpha_X, alpha_Y, col_index, col_hit, col_dist_sq);
    else passed++;
    resetn = 1'b1;
    @(negedge clock);
  endtask

  // Full 320-column frame at angle 90, covering every selection case.
  task automatic test_full_frame();
    int fd_base;
    fd_base = fd_count;
    start_frame(9'd90);
    run_column(0, 0, 13'sd164, 13'sd100, 1'b1, 13'sd100, 13'sd200, 1'b1, 0, 13'sd164, 13'sd100, 27'd4096, 1'b1, 1'b0);
    run_column(3, 0, 13'sd100, 13'sd300, 1'b1, 13'sd130, 13'sd60, 1'b1, 0, 13'sd130, 13'sd60, 27'd2500, 1'b1, 1'b1);
    run_column(2, 2, 13'sd103, 13'sd104, 1'b1, 13'sd105, 13'sd100, 1'b1, 0, 13'sd103, 13'sd104, 27'd25, 1'b1, 1'b0);
    run_column(1, 0, 13'sd101, 13'sd101, 1'b0, 13'sd40, 13'sd100, 1'b1, 0, 13'sd40, 13'sd100, 27'd3600, 1'b1, 1'b1);
    run_column(0, 1, 13'sd50, 13'sd50, 1'b0, 13'sd60, 13'sd60, 1'b0, 0, 13'sd0, 13'sd0, 27'h7FFFFFF, 1'b0, 1'b0);
    run_column(0, 2, 13'sd9, 13'sd9, 1'b0, -13'sd200, -13'sd100, 1'b1, 0, -13'sd200, -13'sd100, 27'd130000, 1'b1, 1'b1);
    run_column(1, 0, 13'sd110, 13'sd100, 1'b1, 13'sd7, 13'sd7, 1'b0, 10, 13'sd110, 13'sd100, 27'd100, 1'b1, 1'b0);
    for (int c = 7; c < 320; c++) begin
      if (c == 319) begin
        checks++;
        if (fd_count !== fd_base) $display("FAIL frame_done_early: got %0d pulses expected %0d", fd_count - fd_base, 0);
        else passed++;
      end
      run_column(1, 0, 13'sd110, 13'sd100, 1'b1, 13'sd7, 13'sd7, 1'b0, 0, 13'sd110, 13'sd100, 27'd100, 1'b1, 1'b0);
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) $display("FAIL frame_done_pulse: got done=%b busy=%b expected 1/0", frame_done, busy);
    else passed++;
    @(negedge clock);
    checks++;
    if (frame_done !== 1'b0 || fd_count !== fd_base + 1) $display("FAIL frame_done_count: got done=%b pulses=%0d expected 0/1", frame_done, fd_count - fd_base);
    else passed++;
  endtask

  // Start angle 330 lands exactly on 360 -> 0.000; next ray wraps to 359.416.
  task automatic test_wrap();
    start_frame(9'd330);
    run_column(0, 0, 13'sd164, 13'sd100, 1'b1, 13'sd100, 13'sd200, 1'b1, 0, 13'sd164, 13'sd100, 27'd4096, 1'b1, 1'b0);
    run_column(0, 0, 13'sd164, 13'sd100, 1'b1, 13'sd100, 13'sd200, 1'b1, 0, 13'sd164, 13'sd100, 27'd4096, 1'b1, 1'b0);
    apply_reset();
  endtask

  // Angle 340 -> 10.000; frame_start mid-sweep is ignored; reset abandons.
  task automatic test_ignore_and_reset();
    int n;
    int fd_base;
    fd_base = fd_count;
    start_frame(9'd340);
    n = 0;
    while (begin_calc !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (alpha_X !== 10'sd10 || alpha_Y !== 10'sd0) $display("FAIL angle340_first: got %0d.%0d expected 10.0", alpha_X, alpha_Y);
    else passed++;
    @(negedge clock);
    player_angle = 9'd100; playerX = 13'sd500;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    h_end_calc = 1'b1; v_end_calc = 1'b1; h_wall_found = 1'b1; v_wall_found = 1'b0;
    h_wallX = 13'sd100; h_wallY = 13'sd110; v_wallX = 13'sd0; v_wallY = 13'sd0;
    @(negedge clock);
    h_end_calc = 1'b0; v_end_calc = 1'b0;
    n = 0;
    while (col_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (alpha_X !== 10'sd10 || alpha_Y !== 10'sd0 || col_index !== 9'd0) $display("FAIL ignore_start_angle: got %0d.%0d idx %0d expected 10.0 idx 0", alpha_X, alpha_Y, col_index);
    else passed++;
    checks++;
    if (col_valid !== 1'b1 || col_dist_sq !== 27'd100 || col_hit !== 1'b1) $display("FAIL ignore_start_player: got valid=%b dist=%0d expected 1/100", col_valid, col_dist_sq);
    else passed++;
    resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || col_valid !== 1'b0 || alpha_X !== 10'sd0 || col_index !== 9'd0) $display("FAIL mid_reset_async: got busy=%b valid=%b ax=%0d idx=%0d expected 0", busy, col_valid, alpha_X, col_index);
    else passed++;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || begin_calc !== 1'b0 || fd_count !== fd_base) $display("FAIL mid_reset_idle: got busy=%b begin=%b pulses=%0d expected 0/0/0", busy, begin_calc, fd_count - fd_base);
    else passed++;
  endtask

`ifdef RAY_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    apply_reset();
    start_frame(9'd0);
    n = 0;
    while (begin_calc !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    n = 0;
    while (col_valid !== 1'b1 && n < 5000) begin @(negedge clock); n++; end
    checks++;
    if (n !== 4098) $display("FAIL timeout_latency: got %0d cycles expected %0d", n, 4098);
    else passed++;
    checks++;
    if (col_hit !== 1'b0 || col_dist_sq !== 27'h7FFFFFF || col_wallX !== 13'sd0) $display("FAIL timeout_result: got hit=%b dist=%0d x=%0d expected 0/134217727/0", col_hit, col_dist_sq, col_wallX);
    else passed++;
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_wrap();
    test_ignore_and_reset();
`ifdef RAY_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ray_sweep_ctrl.md
RAY_SWEEP_CTRL -- requirements
Module: ray_sweep_ctrl

Interface
REQ-001 SHALL take parameter NUM_COLS, default 320: number of screen columns (rays) per frame.
REQ-002 SHALL take parameter ANGLE_STEP_FRAC, default 96: per-column angle decrement in 1/512 degree (96 = 0.1875 deg, i.e. a 60 deg FOV over 320 columns).
REQ-003 SHALL take parameter HALF_FOV, default 30: integer degrees added to the player angle to form the first ray.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state is on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port frame_start, input, 1 bit: one-cycle pulse that starts a sweep.
REQ-007 SHALL have port playerX, playerY, input, 13 bits signed each: player position.
REQ-008 SHALL have port player_angle, input, 9 bits: integer degrees, 0..359.
REQ-009 SHALL have port alpha_X, output, 10 bits signed: integer degrees of the current ray, driven to both intersection finders.
REQ-010 SHALL have port alpha_Y, output, 10 bits signed: fraction of the current ray in 1/512 deg, range 0..511.
REQ-011 SHALL have port begin_calc, output, 1 bit: one-cycle pulse to both finders.
REQ-012 SHALL have ports h_wallX, h_wallY, v_wallX, v_wallY, input, 13 bits signed each: horizontal and vertical finder results.
REQ-013 SHALL have ports h_wall_found, h_end_calc, v_wall_found, v_end_calc, input, 1 bit each: finder status.
REQ-014 SHALL have port col_valid, input col_ready, 1 bit each: column-result handshake to the renderer.
REQ-015 SHALL have port col_index, output, 9 bits: column number.
REQ-016 SHALL have ports col_wallX, col_wallY, output, 13 bits signed each: selected hit point.
REQ-017 SHALL have port col_dist_sq, output, 27 bits unsigned: squared distance to the selected hit.
REQ-018 SHALL have ports col_hit, col_is_vert, output, 1 bit each: wall hit flag and source flag (1 = vertical finder).
REQ-019 SHALL have ports busy, frame_done, output, 1 bit each: sweep in progress; one-cycle pulse after the last column is accepted.

Function
REQ-020 SHALL implement the FSM S_IDLE -> S_ISSUE -> S_WAIT -> S_SELECT -> S_OUTPUT -> (S_ISSUE | S_IDLE).
REQ-021 In S_IDLE, frame_start SHALL latch playerX, playerY and player_angle, set col_index = 0, and set the ray angle to player_angle + HALF_FOV wrapped into 0..359 with fraction 0.
REQ-022 frame_start SHALL be ignored outside S_IDLE.
REQ-023 S_ISSUE SHALL assert begin_calc for exactly one cycle, clear the sticky done flags, and then go to S_WAIT.
REQ-024 In S_WAIT, each end_calc pulse SHALL set its own sticky done flag and capture that finder's wallX, wallY and wall_found in the same cycle.
REQ-025 S_WAIT SHALL exit only when both done flags are set; simultaneous end_calc pulses SHALL both be captured.
REQ-026 S_SELECT (1 cycle) SHALL compute dx^2 + dy^2 for each found hit, with deltas relative to the latched player position, unsigned, 27 bits.
REQ-027 S_SELECT SHALL choose the smaller distance; a tie SHALL select horizontal; if only one hit is found, that one SHALL be chosen.
REQ-028 If neither finder finds a wall, S_SELECT SHALL set col_hit = 0, col_dist_sq = all ones, and col_wallX/col_wallY = 0.
REQ-029 S_OUTPUT SHALL hold col_valid high with stable outputs until col_ready is sampled high; data is accepted on the cycle both are high.
REQ-030 On acceptance, the ray angle SHALL be decremented by ANGLE_STEP_FRAC with borrow from fraction to integer, wrapping below 0 to +360.
REQ-031 On acceptance, col_index SHALL increment; after column NUM_COLS-1 the FSM SHALL return to S_IDLE and pulse frame_done.
REQ-032 busy SHALL be high in every state except S_IDLE.

Reset
REQ-033 While resetn is low: state = S_IDLE, all flags and outputs 0, alpha_X = alpha_Y = 0, col_index = 0.
REQ-034 Reset asserted mid-sweep SHALL abandon the sweep; no frame_done SHALL be issued.

Configuration
REQ-035 With RAY_TIMEOUT_EN defined, a 12-bit counter SHALL run in S_WAIT; on reaching 4095 the block SHALL force any missing done flags with found = 0 and proceed to S_SELECT.
REQ-036 Without RAY_TIMEOUT_EN defined, S_WAIT SHALL wait indefinitely and no counter SHALL be synthesized.

Structure
REQ-037 A shared package SHALL hold the FSM state encodings, ANGLE_FRAC_BITS = 9, the 360-degree constant, and the DIST_MAX constant.
REQ-038 The distance compare SHALL be a sub-module ray_dist_select (combinational: two hits in, selected hit out).

Verification
REQ-039 Scenario: player (100,100), angle 90, frame_start -> first ray alpha 120.000; second ray alpha_X = 119, alpha_Y = 416.
REQ-040 Scenario: angle 340 -> first ray alpha 10.000; a ray starting at 0.000 SHALL wrap to alpha_X = 359, alpha_Y = 416.
REQ-041 Scenario: horizontal hit (164,100), vertical hit (100,200), player (100,100) -> horizontal selected, dist_sq = 4096.
REQ-042 Scenario: v_end_calc 3 cycles before h_end_calc, then simultaneous end_calc pulses -> both results captured; selection correct in both cases.
REQ-043 Scenario: col_ready held low 10 cycles -> col_valid and data stable; col_index advances only after acceptance; frame_done after 320 acceptances.
REQ-044 Scenario: no end_calc with RAY_TIMEOUT_EN -> col_valid after 4096 wait cycles with col_hit = 0; also resetn pulsed mid-sweep -> idle, no frame_done.
